glitch_capture: RTL and testbench

- Bench-side counterpart to the glitch generator: issues the trigger pulse that arms the generator, then times the glitch that comes back.
- Measures the delay from trigger release to the glitch rising edge and the glitch high width, both in CLK cycles. Reports the result with a one-cycle valid strobe.
- Sits on the board opposite the glitch generator: its trigger output drives the generator's trigger pin; the generator's pulse output returns on glitch_in.

---
 rtl/glitch_capture.sv | 223 ++++++++++++++++++++++
 tb/tb_glitch_capture.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_capture.sv
// glitch_capture: issues a trigger pulse to the glitch generator, then times the returning glitch
// (delay from trigger release and high width, in CLK cycles). Optional macro: GLITCH_CAPTURE_MULTI_EN.
module glitch_capture #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned TRIG_LEN = 4,
    parameter int unsigned TIMEOUT  = 60000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic             glitch_in,
    output logic             trig_out,
    output logic             busy,
    output logic             result_valid,
    output logic             timeout,
    output logic [CNT_W-1:0] delay_cnt,
    output logic [CNT_W-1:0] width_cnt
`ifdef GLITCH_CAPTURE_MULTI_EN
    ,
    output logic [7:0]       pulse_cnt
`endif
);

    localparam logic [7:0]       TRIG_LAST = 8'(TRIG_LEN - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TO_FULL   = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT,
        S_MEAS,
        S_DONE
`ifdef GLITCH_CAPTURE_MULTI_EN
        ,
        S_WIN
`endif
    } state_t;

    state_t           state_q, state_d;
    logic             gs_meta_q, gs_q, gs_prev_q;
    logic             gs_rise;
    logic [7:0]       trg_q, trg_d;
    logic [CNT_W-1:0] dly_q, dly_d;
    logic [CNT_W-1:0] lat_dly_q, lat_dly_d;
    logic [CNT_W-1:0] wid_q, wid_d;
    logic [CNT_W-1:0] delay_cnt_q, delay_cnt_d;
    logic [CNT_W-1:0] width_cnt_q, width_cnt_d;
    logic             timeout_q, timeout_d;
    logic             load_meas;
`ifdef GLITCH_CAPTURE_MULTI_EN
    logic [7:0]       pc_q, pc_d;
    logic [7:0]       pulse_cnt_q, pulse_cnt_d;
`endif

    // gs_prev_q tracks gs continuously, so a line already high on WAIT entry is not a rise
    assign gs_rise = gs_q & ~gs_prev_q;

    always_comb begin
        state_d     = state_q;
        trg_d       = trg_q;
        dly_d       = dly_q;
        lat_dly_d   = lat_dly_q;
        wid_d       = wid_q;
        delay_cnt_d = delay_cnt_q;
        width_cnt_d = width_cnt_q;
        timeout_d   = timeout_q;
        load_meas   = 1'b0;
`ifdef GLITCH_CAPTURE_MULTI_EN
        pc_d        = pc_q;
        pulse_cnt_d = pulse_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_TRIG;
                    trg_d     = '0;
                    dly_d     = '0;
                    lat_dly_d = '0;
                    wid_d     = '0;
`ifdef GLITCH_CAPTURE_MULTI_EN
                    pc_d      = '0;
`endif
                end
            end

            S_TRIG: begin
                if (trg_q == TRIG_LAST) begin
                    state_d = S_WAIT;
                end else begin
                    trg_d = trg_q + 8'd1;
                end
            end

            S_WAIT: begin
                dly_d = dly_q + 1'b1;
                if (gs_rise) begin
                    state_d   = S_MEAS;
                    lat_dly_d = dly_q;
                    wid_d     = CNT_W'(1);
`ifdef GLITCH_CAPTURE_MULTI_EN
                    pc_d      = 8'd1;
`endif
                end else if (dly_q >= TO_LAST) begin
                    state_d     = S_DONE;
                    timeout_d   = 1'b1;
                    delay_cnt_d = TO_FULL;
                    width_cnt_d = '0;
`ifdef GLITCH_CAPTURE_MULTI_EN
                    pulse_cnt_d = '0;
`endif
                end
            end

            S_MEAS: begin
`ifdef GLITCH_CAPTURE_MULTI_EN
                // elapsed time since trigger release keeps running to close the window
                if (dly_q < TO_FULL) begin
                    dly_d = dly_q + 1'b1;
                end
`endif
                if (gs_q) begin
                    if (wid_q != '1) begin
                        wid_d = wid_q + 1'b1;
                    end
                end else begin
`ifdef GLITCH_CAPTURE_MULTI_EN
                    if (dly_q >= TO_LAST) begin
                        state_d   = S_DONE;
                        load_meas = 1'b1;
                    end else begin
                        state_d = S_WIN;
                    end
`else
                    state_d   = S_DONE;
                    load_meas = 1'b1;
`endif
                end
            end

`ifdef GLITCH_CAPTURE_MULTI_EN
            S_WIN: begin
                if (dly_q < TO_FULL) begin
                    dly_d = dly_q + 1'b1;
                end
                if (gs_rise && (pc_q != 8'hFF)) begin
                    pc_d = pc_q + 8'd1;
                end
                if (dly_q >= TO_LAST) begin
                    state_d   = S_DONE;
                    load_meas = 1'b1;
                end
            end
`endif

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load_meas) begin
            timeout_d   = 1'b0;
            delay_cnt_d = lat_dly_q;
            width_cnt_d = wid_q;
`ifdef GLITCH_CAPTURE_MULTI_EN
            pulse_cnt_d = pc_d;
`endif
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            gs_meta_q   <= 1'b0;
            gs_q        <= 1'b0;
            gs_prev_q   <= 1'b0;
            trg_q       <= '0;
            dly_q       <= '0;
            lat_dly_q   <= '0;
            wid_q       <= '0;
            delay_cnt_q <= '0;
            width_cnt_q <= '0;
            timeout_q   <= 1'b0;
`ifdef GLITCH_CAPTURE_MULTI_EN
            pc_q        <= '0;
            pulse_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gs_meta_q   <= glitch_in;
            gs_q        <= gs_meta_q;
            gs_prev_q   <= gs_q;
            trg_q       <= trg_d;
            dly_q       <= dly_d;
            lat_dly_q   <= lat_dly_d;
            wid_q       <= wid_d;
            delay_cnt_q <= delay_cnt_d;
            width_cnt_q <= width_cnt_d;
            timeout_q   <= timeout_d;
`ifdef GLITCH_CAPTURE_MULTI_EN
            pc_q        <= pc_d;
            pulse_cnt_q <= pulse_cnt_d;
`endif
        end
    end

    // decoded straight from the state register so reset drops trig_out without a clock
    assign trig_out     = (state_q == S_TRIG);
    assign busy         = (state_q != S_IDLE);
    assign result_valid = (state_q == S_DONE);
    assign timeout      = timeout_q;
    assign delay_cnt    = delay_cnt_q;
    assign width_cnt    = width_cnt_q;
`ifdef GLITCH_CAPTURE_MULTI_EN
    assign pulse_cnt    = pulse_cnt_q;
`endif

endmodule

// File: tb/tb_glitch_capture.sv
// Self-checking bench for glitch_capture: glitch waveforms are scanned by a cycle-level reference
// model that derives delay, width, timeout and the result-strobe cycle from the synchronized line.
module tb_glitch_capture;

    localparam int TL = 4;
`ifdef GLITCH_CAPTURE_MULTI_EN
    localparam int TO = 200;
`else
    localparam int TO = 100;
`endif
    localparam int W0   = TL + 1;   // first WAIT cycle, counted from the start-sampling edge
    localparam int MAXT = 400;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        start;
    logic        glitch_in;
    logic        trig_out;
    logic        busy;
    logic        result_valid;
    logic        timeout;
    logic [15:0] delay_cnt;
    logic [15:0] width_cnt;
`ifdef GLITCH_CAPTURE_MULTI_EN
    logic [7:0]  pulse_cnt;
`endif

    glitch_capture #(
        .CNT_W   (16),
        .TRIG_LEN(TL),
        .TIMEOUT (TO)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .start       (start),
        .glitch_in   (glitch_in),
        .trig_out    (trig_out),
        .busy        (busy),
        .result_valid(result_valid),
        .timeout     (timeout),
        .delay_cnt   (delay_cnt),
        .width_cnt   (width_cnt)
`ifdef GLITCH_CAPTURE_MULTI_EN
        ,
        .pulse_cnt   (pulse_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // wv[t]: glitch_in level during capture cycle t (t=1 is the first trigger cycle)
    bit wv [0:MAXT];
    int m_done, m_dly, m_wid, m_to, m_pc;
    int p_dly = 0, p_wid = 0, p_to = 0, p_pc = 0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, expv);
        end
    endtask

    function automatic bit gs_at(input int t);
        if (t < 2 || t - 2 > MAXT) return 1'b0;
        return wv[t - 2];
    endfunction

    task automatic clear_wv();
        for (int i = 0; i <= MAXT; i++) wv[i] = 1'b0;
    endtask

    task automatic add_pulse(input int from, input int len);
        for (int i = from; i < from + len; i++) if (i >= 0 && i <= MAXT) wv[i] = 1'b1;
    endtask

    task automatic run_model();
        m_to   = 1;
        m_dly  = TO;
        m_wid  = 0;
        m_pc   = 0;
        m_done = W0 + TO;
        for (int t = W0; t < W0 + TO; t++) begin
            if (gs_at(t) && !gs_at(t - 1)) begin
                int n;
                n = 0;
                while (gs_at(t + n)) n++;
                m_to   = 0;
                m_dly  = t - W0;
                m_wid  = n;
                m_pc   = 1;
                m_done = t + n + 1;
`ifdef GLITCH_CAPTURE_MULTI_EN
                if (t + n - W0 < TO - 1) begin
                    for (int u = t + n + 1; u < W0 + TO; u++)
                        if (gs_at(u) && !gs_at(u - 1) && m_pc < 255) m_pc++;
                    m_done = W0 + TO;
                end
`endif
                break;
            end
        end
    endtask

    task automatic check_results(input string tag, input int d, input int w, input int to, input int pc);
        chk_eq($sformatf("%s:delay", tag), 32'(delay_cnt), d);
        chk_eq($sformatf("%s:width", tag), 32'(width_cnt), w);
        chk_eq($sformatf("%s:timeout", tag), 32'(timeout), to);
`ifdef GLITCH_CAPTURE_MULTI_EN
        chk_eq($sformatf("%s:pulses", tag), 32'(pulse_cnt), pc);
`else
        if (pc < 0) $display("unexpected pulse count argument");
`endif
    endtask

    task automatic capture(input string name, input int ex_start, input int abort_t, input bit hold);
        int tend, abort_at, et, eb, ev;
        bit aborted;
        run_model();
        abort_at = hold ? m_done + 3 : abort_t;
        tend     = (abort_at > 0) ? abort_at : m_done + 1;
        aborted  = 1'b0;
        @(posedge CLK); #1;
        start     = 1'b1;
        glitch_in = wv[0];
        for (int t = 1; t <= tend; t++) begin
            @(posedge CLK); #1;
            start     = hold || (t == ex_start);
            glitch_in = wv[t];
            if (t == abort_at) begin
                RST_N = 1'b0;
                #1;
                chk_eq($sformatf("%s:abort_trig", name), 32'(trig_out), 0);
                chk_eq($sformatf("%s:abort_busy", name), 32'(busy), 0);
                chk_eq($sformatf("%s:abort_valid", name), 32'(result_valid), 0);
                aborted = 1'b1;
            end else begin
                @(negedge CLK);
                et = ((t >= 1 && t <= TL) || (hold && t >= m_done + 2 && t <= m_done + 1 + TL)) ? 1 : 0;
                eb = ((t >= 1 && t <= m_done) || (hold && t >= m_done + 2)) ? 1 : 0;
                ev = (t == m_done) ? 1 : 0;
                chk_eq($sformatf("%s:trig@%0d", name, t), 32'(trig_out), et);
                chk_eq($sformatf("%s:busy@%0d", name, t), 32'(busy), eb);
                chk_eq($sformatf("%s:valid@%0d", name, t), 32'(result_valid), ev);
                if (t == 1) check_results($sformatf("%s:held", name), p_dly, p_wid, p_to, p_pc);
                if (t == m_done || t == m_done + 1)
                    check_results($sformatf("%s:res@%0d", name, t), m_dly, m_wid, m_to, m_pc);
            end
        end
        start     = 1'b0;
        glitch_in = 1'b0;
        if (aborted) begin
            @(posedge CLK); #1;
            RST_N = 1'b1;
            @(negedge CLK);
            chk_eq($sformatf("%s:post_rst_busy", name), 32'(busy), 0);
            check_results($sformatf("%s:post_rst", name), 0, 0, 0, 0);
            p_dly = 0; p_wid = 0; p_to = 0; p_pc = 0;
        end else begin
            p_dly = m_dly; p_wid = m_wid; p_to = m_to; p_pc = m_pc;
        end
        repeat (3) @(posedge CLK);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST_N     = 1'b0;
        start     = 1'b0;
        glitch_in = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk_eq("rst:trig", 32'(trig_out), 0);
        chk_eq("rst:busy", 32'(busy), 0);
        chk_eq("rst:valid", 32'(result_valid), 0);
        check_results("rst", 0, 0, 0, 0);
        glitch_in = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        repeat (3) @(posedge CLK);
        #1;

        clear_wv(); add_pulse(W0 + 10, 6);
        capture("nominal", 0, 0, 1'b0);

        clear_wv();
        capture("timeout", 0, 0, 1'b0);

        clear_wv(); add_pulse(1, W0 + 4); add_pulse(W0 + 20, 3);
        capture("prehigh", W0 + 8, 0, 1'b0);

        clear_wv(); add_pulse(W0 + 6, 30);
        capture("abort_meas", 0, W0 + 6 + 2 + 5, 1'b0);
        clear_wv(); add_pulse(W0 + 4, 4);
        capture("after_abort", 0, 0, 1'b0);

        clear_wv(); add_pulse(W0 + TO - 3, 2);
        capture("edge_last", 0, 0, 1'b0);
        clear_wv(); add_pulse(W0 + TO - 2, 2);
        capture("edge_late", 0, 0, 1'b0);

        clear_wv(); add_pulse(W0 + 7, 1);
        capture("width1", 0, 0, 1'b0);

        clear_wv(); add_pulse(W0 + 5, 3);
        capture("b2b", 0, 0, 1'b1);

`ifdef GLITCH_CAPTURE_MULTI_EN
        clear_wv(); add_pulse(W0 + 10, 2); add_pulse(W0 + 20, 2); add_pulse(W0 + 30, 2);
        capture("multi3", 0, 0, 1'b0);
`endif

        for (int i = 0; i < 12; i++) begin
            int kind, a, w, g;
            clear_wv();
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: add_pulse(W0 + int'($urandom_range(0, TO - 12)), int'($urandom_range(1, 8)));
                1: begin
                    a = W0 - 1 + int'($urandom_range(0, 6));
                    add_pulse(1, a);
                    add_pulse(1 + a + int'($urandom_range(1, 10)), int'($urandom_range(1, 6)));
                end
                2: ;
                default: begin
                    a = W0 + int'($urandom_range(0, TO / 2));
                    w = int'($urandom_range(1, 4));
                    g = int'($urandom_range(1, 5));
                    add_pulse(a, w);
                    add_pulse(a + w + g, int'($urandom_range(1, 4)));
                end
            endcase
            capture($sformatf("rnd%0d", i), int'($urandom_range(2, W0 + 1)), 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
